// File: rtl/alu_div_pkg.sv
// rtl/alu_div_pkg.sv - shared types and helpers for the divider scheduler
package alu_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DEF_W = 8;

  // Tag width never collapses to zero bits, even for a single requester.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_sched_rr_arbiter.sv
// rtl/div_sched_rr_arbiter.sv - combinational round-robin grant from a rotating start pointer
module rr_arbiter
  import alu_div_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/div_sched.sv
// rtl/div_sched.sv - round-robin scheduler sharing one divider between N_REQ requesters
// Optional watchdog on the divider wait enabled by defining DIV_TIMEOUT_EN.
module div_sched
  import alu_div_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int W      = DEF_W,
  parameter int ID_W   = id_width(N_REQ),
  parameter int TO_CYC = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [ID_W-1:0]    resp_id,
  output logic [2*W-1:0]     resp_quot,
  output logic               resp_dbz,
  output logic               resp_err,
  output logic               div_start,
  output logic [W-1:0]       div_a,
  output logic [W-1:0]       div_b,
  input  logic [2*W-1:0]     div_quot,
  input  logic               div_done
);

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [W-1:0]      a_q, b_q;
  logic [ID_W-1:0]   id_q;
  logic [2*W-1:0]    quot_q;
  logic              dbz_q;
  logic              first_wait;

  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_any;
  logic [W-1:0]      sel_a, sel_b;
  logic              accept, done_ok, to_hit;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign sel_a  = req_a[int'(gnt_idx)*W +: W];
  assign sel_b  = req_b[int'(gnt_idx)*W +: W];
  assign accept = (state == IDLE) && gnt_any;
  // A done level still high from the previous operation is visible on the first WAIT cycle.
  assign done_ok = (state == WAIT) && !first_wait && div_done;

`ifdef DIV_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYC + 1);

  logic [TO_W-1:0] wait_cnt;
  logic            err_q;

  assign to_hit = (state == WAIT) && !done_ok && (wait_cnt == TO_W'(TO_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == ISSUE) wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + TO_W'(1);
      if (accept) err_q <= 1'b0;
      else if (to_hit) err_q <= 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      quot_q     <= '0;
      dbz_q      <= 1'b0;
      first_wait <= 1'b0;
    end else begin
      state      <= state_nxt;
      first_wait <= (state == ISSUE);
      if (accept) begin
        a_q    <= sel_a;
        b_q    <= sel_b;
        id_q   <= gnt_idx;
        quot_q <= '0;
        dbz_q  <= (sel_b == '0);
        rr_ptr <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
      end else if (done_ok) begin
        quot_q <= div_quot;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    div_start  = 1'b0;
    div_a      = '0;
    div_b      = '0;
    resp_valid = 1'b0;
    resp_id    = '0;
    resp_quot  = '0;
    resp_dbz   = 1'b0;
    resp_err   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = gnt;
        if (accept) state_nxt = (sel_b == '0) ? RESP : ISSUE;
      end
      ISSUE: begin
        div_start = 1'b1;
        div_a     = a_q;
        div_b     = b_q;
        state_nxt = WAIT;
      end
      WAIT: begin
        div_a = a_q;
        div_b = b_q;
        if (done_ok || to_hit) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_id    = id_q;
        resp_quot  = quot_q;
        resp_dbz   = dbz_q;
`ifdef DIV_TIMEOUT_EN
        resp_err   = err_q;
`endif
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
